// File: rtl/writeback_vector_sequencer.sv
// Writeback stage: selects ALU/memory results, writes scalars in one cycle and
// streams a V-bit vector result into the vector register file as V/L lane beats.
module writeback_vector_sequencer #(
    parameter int N = 32,
    parameter int V = 256,
    parameter int R = 5,
    parameter int L = 64
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      RegWriteW,
    input  logic                                      RegWriteVW,
    input  logic                                      MemtoRegW,
    input  logic [N-1:0]                              ALUResultW,
    input  logic [N-1:0]                              ReadDataW,
    input  logic [V-1:0]                              ALUResultVW,
    input  logic [V-1:0]                              ReadDataVW,
    input  logic [R-1:0]                              WA3W,
    output logic [N-1:0]                              ResultW,
    output logic                                      WE3,
    output logic [R-1:0]                              WA3,
    output logic [N-1:0]                              WD3,
    output logic                                      WEV,
    output logic [R-1:0]                              WAV,
    output logic [L-1:0]                              WDV,
    output logic [((V/L) > 1 ? $clog2(V/L) : 1)-1:0] LaneV,
    output logic                                      EnW,
    output logic                                      BusyW
);

    localparam int B  = V / L;
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    typedef enum logic {
        IDLE,
        VBEAT
    } state_t;

    state_t          state, stateNext;
    logic [CW-1:0]   cnt, cntNext;
    logic [V-1:0]    vbuf;
    logic [R-1:0]    abuf;
    logic            capture;
    logic [V-1:0]    vsrc;

    assign ResultW = MemtoRegW ? ReadDataW : ALUResultW;
    assign vsrc    = MemtoRegW ? ReadDataVW : ALUResultVW;

    assign WE3 = RegWriteW & (state == IDLE);
    assign WA3 = WA3W;
    assign WD3 = ResultW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            vbuf  <= '0;
            abuf  <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (capture) begin
                vbuf <= vsrc;
                abuf <= WA3W;
            end
        end
    end

    // Beat 0 is written straight from the pipeline register; later beats come
    // from vbuf/abuf so the frozen register's inputs are never re-sampled.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        capture   = 1'b0;
        WEV       = 1'b0;
        WAV       = WA3W;
        WDV       = vsrc[L-1:0];
        LaneV     = '0;
        EnW       = 1'b1;
        BusyW     = 1'b0;

        unique case (state)
            IDLE: begin
                if (RegWriteVW) begin
                    WEV = 1'b1;
                    if (B > 1) begin
                        EnW       = 1'b0;
                        capture   = 1'b1;
                        cntNext   = CW'(1);
                        stateNext = VBEAT;
                    end
                end
            end
            VBEAT: begin
                WEV   = 1'b1;
                LaneV = cnt;
                WDV   = vbuf[int'(cnt)*L +: L];
                WAV   = abuf;
                BusyW = 1'b1;
                if (cnt == CW'(B - 1)) begin
                    EnW       = 1'b1;
                    cntNext   = '0;
                    stateNext = IDLE;
                end else begin
                    EnW     = 1'b0;
                    cntNext = cnt + CW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_writeback_vector_sequencer.sv
// Self-checking bench for writeback_vector_sequencer: directed and random
// instructions compared beat-by-beat against a transaction-level model.
module tb_writeback_vector_sequencer;

    localparam int N = 32;
    localparam int V = 256;
    localparam int R = 5;
    localparam int L = 64;
    localparam int B = V / L;

    logic          clk = 1'b0;
    logic          rst;
    logic          RegWriteW, RegWriteVW, MemtoRegW;
    logic [N-1:0]  ALUResultW, ReadDataW;
    logic [V-1:0]  ALUResultVW, ReadDataVW;
    logic [R-1:0]  WA3W;
    logic [N-1:0]  ResultW, WD3;
    logic          WE3, WEV, EnW, BusyW;
    logic [R-1:0]  WA3, WAV;
    logic [L-1:0]  WDV;
    logic [1:0]    LaneV;

    int passCount  = 0;
    int checkCount = 0;

    writeback_vector_sequencer #(.N(N), .V(V), .R(R), .L(L)) dut (
        .clk(clk), .rst(rst),
        .RegWriteW(RegWriteW), .RegWriteVW(RegWriteVW), .MemtoRegW(MemtoRegW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .ALUResultVW(ALUResultVW), .ReadDataVW(ReadDataVW),
        .WA3W(WA3W), .ResultW(ResultW), .WE3(WE3), .WA3(WA3), .WD3(WD3),
        .WEV(WEV), .WAV(WAV), .WDV(WDV), .LaneV(LaneV), .EnW(EnW), .BusyW(BusyW)
    );

    always #5 clk = ~clk;

    function automatic logic [V-1:0] rand256();
        logic [V-1:0] r = '0;
        for (int i = 0; i < V / 32; i++) r = {r[V-33:0], 32'($urandom())};
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    endtask

    task automatic driveGarbage(input logic allowVec);
        RegWriteW   = 1'($urandom());
        RegWriteVW  = allowVec & 1'($urandom());
        MemtoRegW   = 1'($urandom());
        ALUResultW  = $urandom();
        ReadDataW   = $urandom();
        ALUResultVW = rand256();
        ReadDataVW  = rand256();
        WA3W        = 5'($urandom());
    endtask

    // One pipeline instruction: beat 0 uses the real inputs, later beats
    // scramble the (frozen) inputs so only captured data may appear.
    task automatic applyStimulus(input logic rw, input logic rvw, input logic m2r,
                                 input logic [N-1:0] alu, input logic [N-1:0] rd,
                                 input logic [V-1:0] aluv, input logic [V-1:0] rdv,
                                 input logic [R-1:0] wa);
        logic [V-1:0] src;
        logic [N-1:0] res;
        int beats;
        src   = m2r ? rdv : aluv;
        res   = m2r ? rd : alu;
        beats = rvw ? B : 1;
        for (int k = 0; k < beats; k++) begin
            @(negedge clk);
            if (k == 0) begin
                RegWriteW = rw; RegWriteVW = rvw; MemtoRegW = m2r;
                ALUResultW = alu; ReadDataW = rd;
                ALUResultVW = aluv; ReadDataVW = rdv; WA3W = wa;
            end else begin
                driveGarbage(1'b1);
            end
            #1;
            checkOutput("ResultW", 64'(ResultW), 64'(MemtoRegW ? ReadDataW : ALUResultW));
            checkOutput("WE3", 64'(WE3), 64'(rw && k == 0));
            if (k == 0) begin
                checkOutput("WA3", 64'(WA3), 64'(wa));
                checkOutput("WD3", 64'(WD3), 64'(res));
            end
            checkOutput("WEV", 64'(WEV), 64'(rvw));
            checkOutput("BusyW", 64'(BusyW), 64'(k != 0));
            checkOutput("EnW", 64'(EnW), 64'(!rvw || k == B - 1));
            if (rvw) begin
                checkOutput("WAV", 64'(WAV), 64'(wa));
                checkOutput("LaneV", 64'(LaneV), 64'(k));
                checkOutput("WDV", 64'(WDV), 64'(src >> (k * L)));
            end
            @(posedge clk);
        end
    endtask

    initial begin
        logic [V-1:0] vecA, vecB;
        rst = 1'b1;
        RegWriteW = 0; RegWriteVW = 0; MemtoRegW = 0;
        ALUResultW = '0; ReadDataW = '0; ALUResultVW = '0; ReadDataVW = '0; WA3W = '0;
        #2;
        checkOutput("rst_WEV", 64'(WEV), 64'd0);
        checkOutput("rst_EnW", 64'(EnW), 64'd1);
        checkOutput("rst_BusyW", 64'(BusyW), 64'd0);
        checkOutput("rst_LaneV", 64'(LaneV), 64'd0);
        checkOutput("rst_WE3", 64'(WE3), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed tests");
        applyStimulus(1, 0, 0, 32'h0000_00A5, $urandom(), rand256(), rand256(), 5'd3);
        vecA = {64'h4, 64'h3, 64'h2, 64'h1};
        applyStimulus(0, 1, 0, $urandom(), $urandom(), vecA, rand256(), 5'd7);
        vecB = {4{64'hDEAD_BEEF_0000_0001}};
        applyStimulus(0, 1, 1, $urandom(), $urandom(), '1, vecB, 5'd11);
        applyStimulus(1, 1, 0, 32'h1234_5678, $urandom(), rand256(), rand256(), 5'd5);
        applyStimulus(0, 1, 0, $urandom(), $urandom(), rand256(), rand256(), 5'd9);

        $display("[TB] random tests");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom()), 1'($urandom()), 1'($urandom()),
                          $urandom(), $urandom(), rand256(), rand256(), 5'($urandom()));
        end

        $display("[TB] reset mid-sequence");
        @(negedge clk);
        RegWriteW = 0; RegWriteVW = 1; MemtoRegW = 0;
        ALUResultVW = {64'h44, 64'h33, 64'h22, 64'h11}; WA3W = 5'd12;
        #1;
        checkOutput("mid_lane0", 64'(WDV), 64'h11);
        @(posedge clk);
        @(negedge clk);
        driveGarbage(1'b0);
        #1;
        checkOutput("mid_lane1", 64'(WDV), 64'h22);
        @(posedge clk);
        @(negedge clk);
        driveGarbage(1'b0);
        #1;
        checkOutput("mid_lane2", 64'(LaneV), 64'd2);
        checkOutput("mid_WEV2", 64'(WEV), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_WEV", 64'(WEV), 64'd0);
        checkOutput("arst_BusyW", 64'(BusyW), 64'd0);
        checkOutput("arst_EnW", 64'(EnW), 64'd1);
        checkOutput("arst_LaneV", 64'(LaneV), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        RegWriteVW = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("post_WEV", 64'(WEV), 64'd0);
            checkOutput("post_BusyW", 64'(BusyW), 64'd0);
            checkOutput("post_EnW", 64'(EnW), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        applyStimulus(0, 1, 0, $urandom(), $urandom(), rand256(), rand256(), 5'd20);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
